// File: rtl/imem_loadable.sv
// Writable instruction memory: loaded over a ready/valid byte stream, read by the
// fetch stage through a registered one-cycle port. Unloaded words read as HALT_WORD.
module imem_loadable #(
  parameter int            AW        = 8,
  parameter int            DW        = 16,
  parameter int            DEPTH     = 256,
  parameter logic [DW-1:0] HALT_WORD = 'h0800
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_err,
  output logic          busy,
  input  logic          fetch_en,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] iout,
  output logic          iout_valid
);

  localparam int BPW = DW / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int PW  = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [CW-1:0]      bcnt_q, bcnt_d;
  logic [DW-1:0]      asm_q, asm_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DW-1:0]      iout_q, iout_d;
  logic               iout_valid_q, iout_valid_d;

  logic [DW-1:0]      mem [DEPTH];

  logic               accept;
  logic               full;
  logic               last_byte;
  logic               wr_en;
  logic [DW-1:0]      wr_word;
  logic [IW-1:0]      widx;
  logic [IW-1:0]      fidx;
  logic               in_range;
  logic               fetch_hit;

  assign accept    = (state_q == S_LOAD) && ld_valid;
  assign full      = (wptr_q == PW'(DEPTH));
  assign last_byte = (bcnt_q == CW'(BPW - 1));
  assign widx      = wptr_q[IW-1:0];
  assign fidx      = fetch_addr[IW-1:0];
  // Earlier bytes of the word shift up so the first byte ends in the top lane.
  assign wr_word   = (asm_q << 8) | DW'(ld_data);

  if (DEPTH >= (1 << AW)) begin : g_full_space
    assign in_range = 1'b1;
  end else begin : g_part_space
    assign in_range = (fetch_addr < AW'(DEPTH));
  end

  assign fetch_hit = in_range && valid_q[fidx];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    wptr_d       = wptr_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    done_d       = 1'b0;
    err_d        = err_q;
    iout_d       = iout_q;
    iout_valid_d = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The fetch sees pre-clear valid bits even when a load starts this cycle.
        if (fetch_en) begin
          iout_valid_d = 1'b1;
          iout_d       = fetch_hit ? mem[fidx] : HALT_WORD;
        end
        if (ld_start) begin
          state_d = S_LOAD;
          valid_d = '0;
          wptr_d  = '0;
          bcnt_d  = '0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          if (full) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (last_byte) begin
            wr_en         = 1'b1;
            valid_d[widx] = 1'b1;
            wptr_d        = wptr_q + PW'(1);
            bcnt_d        = '0;
            if (ld_last) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            asm_d  = wr_word;
            bcnt_d = bcnt_q + CW'(1);
            if (ld_last) begin
              err_d   = 1'b1;
              bcnt_d  = '0;
              state_d = S_IDLE;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      wptr_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      iout_q       <= HALT_WORD;
      iout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      wptr_q       <= wptr_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      done_q       <= done_d;
      err_q        <= err_d;
      iout_q       <= iout_d;
      iout_valid_q <= iout_valid_d;
    end
  end

  // NOTE: the array has no reset; the valid bits alone decide what a fetch may return.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[widx] <= wr_word;
    end
  end

  assign ld_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign ld_done    = done_q;
  assign ld_err     = err_q;
  assign iout       = iout_q;
  assign iout_valid = iout_valid_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: table-driven fetch checks after each load,
// plus hand-written sequences for errors, reset mid-load and fetch/load overlap.
module tb_imem_loadable;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;
  logic        busy;
  logic        fetch_en;
  logic [7:0]  fetch_addr;
  logic [15:0] iout;
  logic        iout_valid;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int done_ref;

  typedef struct {
    int          phase;
    logic [7:0]  addr;
    logic [15:0] exp;
  } fvec_t;

  fvec_t tbl[$];

  imem_loadable dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_err     (ld_err),
    .busy       (busy),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .iout       (iout),
    .iout_valid (iout_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ld_done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic check_w(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [15:0] e, input string nm);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
    check_b({nm, "_valid"}, iout_valid, 1'b1);
    check_w(nm, iout, e);
  endtask

  task automatic run_phase(input int p);
    foreach (tbl[i]) begin
      if (tbl[i].phase == p)
        do_fetch(tbl[i].addr, tbl[i].exp, $sformatf("p%0d_fetch_%02h", p, tbl[i].addr));
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int n;
    ld_valid = 1'b0;
    repeat (gap) tick();
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    n = 0;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ld_ready) begin
      total++;
      bad++;
      $display("FAIL ld_ready_timeout: got 0 want 1 (byte %h)", d);
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    tbl = '{
      '{0, 8'h00, 16'h0800}, '{0, 8'hFF, 16'h0800},
      '{1, 8'h00, 16'h1810}, '{1, 8'h01, 16'hB696}, '{1, 8'h02, 16'h0800},
      '{2, 8'h00, 16'h1234}, '{2, 8'h01, 16'h0800},
      '{3, 8'hFF, 16'hFEFF}, '{3, 8'h00, 16'h0001}, '{3, 8'h10, 16'h2021},
      '{4, 8'h00, 16'hA1B2}, '{4, 8'h01, 16'hC3D4}, '{4, 8'h02, 16'hE5F6},
      '{4, 8'h03, 16'h0800}, '{4, 8'hFF, 16'h0800},
      '{5, 8'h00, 16'h0800},
      '{6, 8'h00, 16'h99AA}, '{6, 8'h01, 16'hBBCC}, '{6, 8'h02, 16'h0800}
    };

    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    ld_last = 1'b0; fetch_en = 1'b0; fetch_addr = 8'h00;
    repeat (2) tick();

    // Reset state
    check_w("rst_iout", iout, 16'h0800);
    check_b("rst_iout_valid", iout_valid, 1'b0);
    check_b("rst_ld_ready", ld_ready, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_ld_done", ld_done, 1'b0);
    check_b("rst_ld_err", ld_err, 1'b0);
    rst_n = 1'b1;
    tick();
    check_b("idle_no_fetch_valid", iout_valid, 1'b0);
    run_phase(0);
    tick();
    check_b("fetch_drop_valid", iout_valid, 1'b0);
    check_w("fetch_drop_hold", iout, 16'h0800);

    // Clean two-word load
    start_load();
    check_b("load_busy", busy, 1'b1);
    check_b("load_ready", ld_ready, 1'b1);
    done_ref = done_cnt;
    send_byte(8'h18, 1'b0, 0);
    send_byte(8'h10, 1'b0, 0);
    send_byte(8'hB6, 1'b0, 0);
    send_byte(8'h96, 1'b1, 0);
    check_b("load1_done_pulse", ld_done, 1'b1);
    check_b("load1_idle", busy, 1'b0);
    tick();
    check_b("load1_done_cleared", ld_done, 1'b0);
    check_i("load1_done_count", done_cnt - done_ref, 1);
    run_phase(1);

    // Short final word
    start_load();
    done_ref = done_cnt;
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h56, 1'b1, 0);
    check_b("short_err", ld_err, 1'b1);
    check_b("short_idle", busy, 1'b0);
    tick();
    check_i("short_no_done", done_cnt - done_ref, 0);
    run_phase(2);

    // Overflow: 512 bytes fill the array, the 513th is an error
    start_load();
    done_ref = done_cnt;
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0, 0);
    check_b("full_still_busy", busy, 1'b1);
    check_b("full_no_err_yet", ld_err, 1'b0);
    send_byte(8'h55, 1'b0, 0);
    check_b("ovf_err", ld_err, 1'b1);
    check_b("ovf_idle", busy, 1'b0);
    tick();
    check_i("ovf_no_done", done_cnt - done_ref, 0);
    run_phase(3);
    start_load();
    check_b("restart_clears_err", ld_err, 1'b0);

    // Fetch blocked during LOAD; gapped byte stream
    fetch_en = 1'b1;
    fetch_addr = 8'h00;
    tick();
    check_b("load_fetch_valid", iout_valid, 1'b0);
    check_w("load_fetch_hold", iout, 16'h2021);
    fetch_en = 1'b0;
    done_ref = done_cnt;
    send_byte(8'hA1, 1'b0, $urandom_range(0, 3));
    send_byte(8'hB2, 1'b0, $urandom_range(0, 3));
    send_byte(8'hC3, 1'b0, $urandom_range(0, 3));
    send_byte(8'hD4, 1'b0, $urandom_range(0, 3));
    send_byte(8'hE5, 1'b0, $urandom_range(0, 3));
    send_byte(8'hF6, 1'b1, $urandom_range(0, 3));
    tick();
    check_i("gap_done_count", done_cnt - done_ref, 1);
    run_phase(4);

    // Reset mid-load
    start_load();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check_w("midrst_iout", iout, 16'h0800);
    check_b("midrst_iout_valid", iout_valid, 1'b0);
    check_b("midrst_ld_ready", ld_ready, 1'b0);
    check_b("midrst_busy", busy, 1'b0);
    check_b("midrst_ld_err", ld_err, 1'b0);
    check_b("midrst_ld_done", ld_done, 1'b0);
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    run_phase(5);

    // ld_start and fetch_en together: fetch returns pre-clear contents
    start_load();
    send_byte(8'h77, 1'b0, 0);
    send_byte(8'h88, 1'b1, 0);
    do_fetch(8'h00, 16'h7788, "preload_fetch");
    ld_start = 1'b1;
    fetch_en = 1'b1;
    fetch_addr = 8'h00;
    tick();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    check_w("overlap_iout", iout, 16'h7788);
    check_b("overlap_valid", iout_valid, 1'b1);
    check_b("overlap_busy", busy, 1'b1);

    // ld_start inside LOAD must not restart the write pointer
    done_ref = done_cnt;
    send_byte(8'h99, 1'b0, 0);
    send_byte(8'hAA, 1'b0, 0);
    ld_start = 1'b1;
    send_byte(8'hBB, 1'b0, 0);
    ld_start = 1'b0;
    send_byte(8'hCC, 1'b1, 0);
    tick();
    check_i("restart_ignored_done", done_cnt - done_ref, 1);
    run_phase(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, writable successor to the hard-coded instruction ROM.
- Holds the CPU program in an on-chip array, loaded at run time over a byte-stream port with a ready/valid handshake.
- The fetch stage reads it through a registered, one-cycle-latency port.
- Words never written in the current load read back as the HALT encoding, so a runaway PC halts the core.

Parameters:
- AW, 8, fetch/word address width.
- DW, 16, instruction width; must be a multiple of 8.
- DEPTH, 256, number of words; must be ≤ 2**AW.
- HALT_WORD, 16'h0800, value returned for unloaded or out-of-range words (HALT opcode, zero operands).

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  begin a load; sampled in IDLE only.
- ld_valid  in  1  ld_data carries a byte.
- ld_data  in  8  program byte, big-endian within a word.
- ld_last  in  1  qualifies the final byte of the program.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse: load completed cleanly.
- ld_err  out  1  sticky: last load malformed or overflowed.
- busy  out  1  state is LOAD.
- fetch_en  in  1  fetch request.
- fetch_addr  in  AW  word address.
- iout  out  DW  fetched instruction.
- iout_valid  out  1  iout updated by a fetch issued last cycle.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all per-word valid bits=0; wptr=0; byte count=0.
  - iout=HALT_WORD; iout_valid=0; ld_ready=0; ld_done=0; ld_err=0; busy=0.
  - Array contents are don't-care.
  - Reset asserted mid-load discards the program.
- FSM states:
  - IDLE --ld_start--> LOAD. On the transition: clear all valid bits, wptr=0, byte count=0, ld_err=0.
  - LOAD --accepted byte with ld_last and byte completing a word--> IDLE, with ld_done=1 for one cycle.
  - LOAD --error--> IDLE, with ld_err=1 and no ld_done.
- ld_start while in LOAD is ignored.
- Byte handshake: ld_ready=1 iff state=LOAD. A byte is accepted when ld_valid & ld_ready.
- Word assembly: BPW=DW/8 bytes per word. The first accepted byte of a word lands in bits [DW-1:DW-8].
- Word write: on acceptance of the BPW-th byte, in the same clock edge:
  - mem[wptr] <= assembled word; valid[wptr] <= 1.
  - wptr increments; byte count returns to 0.
- Error, short word: ld_last on a byte that does not complete a word. The partial word is discarded and earlier words stay valid.
- Error, overflow: a byte accepted when wptr=DEPTH, i.e. the array is full and ld_last was not seen. The byte is dropped.
- Fetch:
  - fetch_en=1 in IDLE → next cycle iout_valid=1.
  - iout = mem[fetch_addr] if fetch_addr<DEPTH and valid[fetch_addr], else HALT_WORD.
- fetch_en=0 → iout holds its value and iout_valid=0 next cycle.
- fetch_en=1 in LOAD is ignored: iout holds, iout_valid=0.
- ld_start and fetch_en in the same IDLE cycle: the fetch returns pre-clear contents, and LOAD is entered.
- Write and fetch to the same address cannot coincide, because fetch is blocked in LOAD.
- Latency: fetch 1 cycle. A word becomes readable the cycle after returning to IDLE.

Test Plan:
- Reset, then fetch addr 0x00 and 0xFF → iout=16'h0800, iout_valid=1 one cycle after each fetch_en; before any fetch, iout=0x0800 and iout_valid=0.
- ld_start; bytes 0x18,0x10,0xB6,0x96 (ld_last on 4th) → ld_done pulses once; fetch 0 → 16'h1810; fetch 1 → 16'hB696; fetch 2 → 16'h0800.
- ld_start; bytes 0x12,0x34,0x56 with ld_last on 0x56 → ld_err=1, no ld_done; fetch 0 → 16'h1234; fetch 1 → 16'h0800.
- ld_start; 512 bytes without ld_last, then 1 more byte → ld_err=1, state IDLE; fetch 0xFF → last loaded word; next ld_start clears ld_err.
- During LOAD, drive fetch_en=1, addr 0 → iout_valid stays 0 and iout unchanged; toggle ld_valid randomly → words assemble correctly regardless of gaps.
- Assert rst_n=0 after 3 accepted bytes → all outputs at reset values; fetch 0 → 16'h0800. Then ld_start with fetch_en in the same cycle → fetch returns the old word, and busy=1 next cycle.
